// File: rtl/systolic_pkg.sv
// systolic_pkg: helpers shared by the systolic array input skew and output deskew stages.
package systolic_pkg;
  localparam int ELEM_W = 8;
  typedef logic [ELEM_W-1:0] elem_t;
  function automatic int deskew_depth(input int k, input int length);
    return length - 1 - k;
  endfunction
  function automatic int row_cnt_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction
endpackage

// File: rtl/systolic_output_deskew_if.sv
// systolic_output_deskew_if: skewed array-edge input and aligned result-row output bus.
interface systolic_output_deskew_if #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 5
);
  logic                         IN_VALID;
  logic [LENGTH-1:0][WIDTH-1:0] Inputs;
  logic [LENGTH-1:0][WIDTH-1:0] Outputs;
  logic                         OUT_VALID;
  logic                         OUT_LAST;
  logic                         BUSY;
  modport master (output IN_VALID, Inputs, input Outputs, OUT_VALID, OUT_LAST, BUSY);
  modport slave (input IN_VALID, Inputs, output Outputs, OUT_VALID, OUT_LAST, BUSY);
endinterface

// File: rtl/systolic_delay_line.sv
// systolic_delay_line: DEPTH-stage enabled shift register; DEPTH=0 is a pass-through.
module systolic_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             ASYNC_RST,
  input  logic             SYNC_RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_any
);
  if (DEPTH == 0) begin : g_wire
    assign o_q   = i_d;
    assign o_any = 1'b0;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] r_sr;
    always_ff @(posedge CLK or posedge ASYNC_RST)
      if (ASYNC_RST) r_sr <= '0;
      else if (SYNC_RST) r_sr <= '0;
      else if (EN) begin
        r_sr[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
      end
    assign o_q   = r_sr[DEPTH-1];
    // For the 1-bit valid chain this is the OR of every stage.
    assign o_any = |r_sr;
  end
endmodule

// File: rtl/systolic_output_deskew.sv
// systolic_output_deskew: re-aligns skewed systolic result columns into whole rows.
// Define SYSTOLIC_DESKEW_LAST_EN to build the tile row counter behind OUT_LAST.
module systolic_output_deskew
  import systolic_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 5,
  parameter int ROWS   = 5
) (
  input logic                     CLK,
  input logic                     ASYNC_RST,
  input logic                     SYNC_RST,
  input logic                     EN,
  systolic_output_deskew_if.slave bus
);
  logic [LENGTH-1:0][WIDTH-1:0] w_col;
  logic [LENGTH-1:0]            w_unused_any;
  logic                         w_vld;
  logic                         w_busy;
  logic                         w_last;
  logic [LENGTH-1:0][WIDTH-1:0] r_out;
  logic                         r_vld;
  for (genvar k = 0; k < LENGTH; k++) begin : g_col
    systolic_delay_line #(.WIDTH(WIDTH), .DEPTH(deskew_depth(k, LENGTH))) u_dl (
      .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
      .i_d(bus.Inputs[k]), .o_q(w_col[k]), .o_any(w_unused_any[k])
    );
  end
  systolic_delay_line #(.WIDTH(1), .DEPTH(LENGTH-1)) u_vld (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
    .i_d(bus.IN_VALID), .o_q(w_vld), .o_any(w_busy)
  );
  always_ff @(posedge CLK or posedge ASYNC_RST)
    if (ASYNC_RST) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else if (SYNC_RST) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else if (EN) begin
      r_vld <= w_vld;
      if (w_vld) r_out <= w_col;
    end
`ifdef SYSTOLIC_DESKEW_LAST_EN
  localparam int CW = row_cnt_w(ROWS);
  logic [CW-1:0] r_cnt;
  logic          r_last;
  always_ff @(posedge CLK or posedge ASYNC_RST)
    if (ASYNC_RST) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (SYNC_RST) begin
      r_cnt  <= '0;
      r_last <= 1'b0;
    end else if (EN) begin
      r_last <= w_vld && (r_cnt == CW'(ROWS-1));
      if (w_vld) r_cnt <= (r_cnt == CW'(ROWS-1)) ? '0 : r_cnt + 1'b1;
    end
  assign w_last = r_last;
`else
  assign w_last = 1'b0;
`endif
  assign bus.Outputs   = r_out;
  assign bus.OUT_VALID = r_vld;
  assign bus.OUT_LAST  = w_last;
  assign bus.BUSY      = w_busy;
endmodule

// File: tb/tb_systolic_output_deskew.sv
// tb_systolic_output_deskew: directed table and sequence checks of the output deskew stage.
module tb_systolic_output_deskew;
  localparam int W = 8;
  localparam int L = 5;
  localparam int R = 5;
`ifdef SYSTOLIC_DESKEW_LAST_EN
  localparam logic LAST_ON = 1'b1;
`else
  localparam logic LAST_ON = 1'b0;
`endif
  typedef logic [L-1:0][W-1:0] row_t;
  typedef struct {
    logic in_vld;
    row_t din;
    logic exp_vld;
    logic exp_last;
    logic exp_busy;
    row_t exp_out;
  } vec_t;
  logic CLK = 1'b0;
  logic ASYNC_RST, SYNC_RST, EN;
  int total = 0;
  int bad = 0;
  vec_t tab [10];
  systolic_output_deskew_if #(.WIDTH(W), .LENGTH(L)) bus ();
  systolic_output_deskew #(.WIDTH(W), .LENGTH(L), .ROWS(R)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN), .bus(bus.slave)
  );
  always #5 CLK = ~CLK;

  function automatic row_t mk(input logic [7:0] e0, e1, e2, e3, e4);
    row_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3; r[4] = e4;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic v, input logic last, input logic busy, input row_t o);
    chk({tag, ".valid"}, 64'(bus.OUT_VALID), 64'(v));
    chk({tag, ".last"}, 64'(bus.OUT_LAST), 64'(last));
    chk({tag, ".busy"}, 64'(bus.BUSY), 64'(busy));
    chk({tag, ".out"}, 64'(bus.Outputs), 64'(o));
  endtask

  task automatic tick(input logic v, input row_t d, input logic en);
    bus.IN_VALID = v;
    bus.Inputs = d;
    EN = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic areset();
    ASYNC_RST = 1'b1;
    #1;
    ASYNC_RST = 1'b0;
  endtask

  // Drives n back-to-back skewed rows (element k of row r = base+10r+k) and checks every cycle.
  task automatic run_rows(input string tag, input int n, input int first, input logic [7:0] base);
    row_t d, eo;
    logic have = 1'b0;
    eo = '0;
    for (int c = 0; c <= n + L - 2; c++) begin
      for (int k = 0; k < L; k++)
        d[k] = (c - k >= 0 && c - k < n) ? 8'(int'(base) + 10 * (c - k) + k) : 8'hFF;
      tick(c < n, d, 1'b1);
      if (c >= L - 1) begin
        for (int k = 0; k < L; k++) eo[k] = 8'(int'(base) + 10 * (c - L + 1) + k);
        have = 1'b1;
        chk_state($sformatf("%s.r%0d", tag, c - L + 1), 1'b1,
                  LAST_ON && ((first + c - L + 1) % R == R - 1), c <= n + L - 3, eo);
      end else begin
        chk({tag, ".pre_valid"}, 64'(bus.OUT_VALID), 64'(0));
        chk({tag, ".pre_busy"}, 64'(bus.BUSY), 64'(1));
        if (have) chk({tag, ".pre_out"}, 64'(bus.Outputs), 64'(eo));
      end
    end
  endtask

  initial begin
    tab[0] = '{1'b1, mk(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 1'b0, 1'b1, '0};
    tab[1] = '{1'b1, mk(8'h0A, 8'h01, 8'hFF, 8'hFF, 8'hFF), 1'b0, 1'b0, 1'b1, '0};
    tab[2] = '{1'b1, mk(8'h14, 8'h0B, 8'h02, 8'hFF, 8'hFF), 1'b0, 1'b0, 1'b1, '0};
    tab[3] = '{1'b1, mk(8'h1E, 8'h15, 8'h0C, 8'h03, 8'hFF), 1'b0, 1'b0, 1'b1, '0};
    tab[4] = '{1'b1, mk(8'h28, 8'h1F, 8'h16, 8'h0D, 8'h04), 1'b1, 1'b0, 1'b1,
               mk(8'h00, 8'h01, 8'h02, 8'h03, 8'h04)};
    tab[5] = '{1'b0, mk(8'hFF, 8'h29, 8'h20, 8'h17, 8'h0E), 1'b1, 1'b0, 1'b1,
               mk(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E)};
    tab[6] = '{1'b0, mk(8'hFF, 8'hFF, 8'h2A, 8'h21, 8'h18), 1'b1, 1'b0, 1'b1,
               mk(8'h14, 8'h15, 8'h16, 8'h17, 8'h18)};
    tab[7] = '{1'b0, mk(8'hFF, 8'hFF, 8'hFF, 8'h2B, 8'h22), 1'b1, 1'b0, 1'b1,
               mk(8'h1E, 8'h1F, 8'h20, 8'h21, 8'h22)};
    tab[8] = '{1'b0, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h2C), 1'b1, LAST_ON, 1'b0,
               mk(8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C)};
    tab[9] = '{1'b0, mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b0, 1'b0, 1'b0,
               mk(8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C)};
    ASYNC_RST = 1'b0;
    SYNC_RST = 1'b0;
    EN = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.Inputs = '0;
    #2;
    ASYNC_RST = 1'b1;
    #1;
    chk_state("reset", 1'b0, 1'b0, 1'b0, '0);
    ASYNC_RST = 1'b0;
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk_state("reset_idle", 1'b0, 1'b0, 1'b0, '0);

    for (int k = 0; k < L; k++) begin
      row_t d;
      d = '1;
      d[k] = 8'(k + 1);
      tick(k == 0, d, 1'b1);
      if (k < L - 1) chk_state($sformatf("single.e%0d", k), 1'b0, 1'b0, 1'b1, '0);
    end
    chk_state("single.out", 1'b1, 1'b0, 1'b0, mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05));
    tick(1'b0, '1, 1'b1);
    chk_state("single.hold", 1'b0, 1'b0, 1'b0, mk(8'h01, 8'h02, 8'h03, 8'h04, 8'h05));
    areset();
    chk_state("async_mid", 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 10; i++) begin
      tick(tab[i].in_vld, tab[i].din, 1'b1);
      chk_state($sformatf("b2b.%0d", i), tab[i].exp_vld, tab[i].exp_last, tab[i].exp_busy, tab[i].exp_out);
    end
`ifdef SYSTOLIC_DESKEW_LAST_EN
    chk("b2b.cnt", 64'(dut.r_cnt), 64'(0));
`endif

    areset();
    for (int i = 0; i < 10; i++) begin
      tick(tab[i].in_vld, tab[i].din, 1'b1);
      chk_state($sformatf("stall.%0d", i), tab[i].exp_vld, tab[i].exp_last, tab[i].exp_busy, tab[i].exp_out);
      if (i == 5)
        for (int s = 0; s < 3; s++) begin
          tick(1'b1, '1, 1'b0);
          chk_state($sformatf("stall.hold%0d", s), tab[5].exp_vld, tab[5].exp_last, tab[5].exp_busy, tab[5].exp_out);
        end
    end

    areset();
    run_rows("pre", 2, 0, 8'h60);
    tick(1'b1, mk(8'h70, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1'b1);
    tick(1'b0, mk(8'hFF, 8'h71, 8'hFF, 8'hFF, 8'hFF), 1'b1);
    SYNC_RST = 1'b1;
    tick(1'b0, mk(8'hFF, 8'hFF, 8'h72, 8'hFF, 8'hFF), 1'b0);
    SYNC_RST = 1'b0;
    chk_state("srst", 1'b0, 1'b0, 1'b0, '0);
`ifdef SYSTOLIC_DESKEW_LAST_EN
    chk("srst.cnt", 64'(dut.r_cnt), 64'(0));
`endif
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '1, 1'b1);
      chk_state($sformatf("srst.idle%0d", i), 1'b0, 1'b0, 1'b0, '0);
    end
    run_rows("post", 5, 0, 8'h80);

    areset();
    run_rows("wrap", 7, 0, 8'h10);
`ifdef SYSTOLIC_DESKEW_LAST_EN
    chk("wrap.cnt", 64'(dut.r_cnt), 64'(2));
`endif
    tick(1'b0, '1, 1'b1);
    chk_state("wrap.idle", 1'b0, 1'b0, 1'b0, mk(8'h4C, 8'h4D, 8'h4E, 8'h4F, 8'h50));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
